// File: rtl/led_row_scheduler.sv
// TLC5941 row sequencer for the NX4 panel: one DC load after reset,
// then GS rows displayed while the next row is shifted in the background.
module led_row_scheduler #(
    parameter int NUM_ROWS  = 8,
    parameter int GS_BITS   = 576,
    parameter int DC_BITS   = 288,
    parameter int GS_CYCLES = 4096,
    localparam int W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int CW = (GS_CYCLES > 1) ? $clog2(GS_CYCLES) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         gsclk_tick,
    input  logic         dc_reload,
    input  logic         shift_done,
    output logic         shift_start,
    output logic [9:0]   shift_len,
    output logic [W-1:0] shift_row,
    output logic         led_mode,
    output logic         led_blank,
    output logic         led_xlat,
    output logic [W-1:0] row_sel,
    output logic         frame_done,
    output logic         underrun
);

    localparam logic [9:0]    DC_LEN   = 10'(DC_BITS);
    localparam logic [9:0]    GS_LEN   = 10'(GS_BITS);
    localparam logic [W-1:0]  LAST_ROW = W'(NUM_ROWS - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(GS_CYCLES - 1);

    typedef enum logic [2:0] {
        DC_SHIFT,
        DC_LATCH,
        PRELOAD,
        SWAP_B,
        SWAP_X,
        DISPLAY,
        STALL
    } state_t;

    state_t        state_q, state_d;
    logic          cmd_pend_q, cmd_pend_d;
    logic          done_seen_q, done_seen_d;
    logic          reload_q, reload_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          start_d;
    logic [9:0]    len_d;
    logic [W-1:0]  row_d;
    logic          mode_d;
    logic          blank_d;
    logic          xlat_d;
    logic [W-1:0]  rsel_d;
    logic          frame_d;
    logic          under_d;

    logic          done_ok;
    logic          period_end;
    logic [W-1:0]  next_row;

    // A done pulse only counts for an outstanding command whose start
    // pulse has already been seen by the shifter.
    assign done_ok    = cmd_pend_q && !shift_start && shift_done;
    assign period_end = gsclk_tick && (cnt_q == CNT_END);
    assign next_row   = (row_sel == LAST_ROW) ? '0 : row_sel + 1'b1;

    // State and all outputs are registered so reset lands on the next edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= DC_SHIFT;
            cmd_pend_q  <= 1'b0;
            done_seen_q <= 1'b0;
            reload_q    <= 1'b0;
            cnt_q       <= '0;
            shift_start <= 1'b0;
            shift_len   <= '0;
            shift_row   <= '0;
            led_mode    <= 1'b0;
            led_blank   <= 1'b1;
            led_xlat    <= 1'b0;
            row_sel     <= '0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_pend_q  <= cmd_pend_d;
            done_seen_q <= done_seen_d;
            reload_q    <= reload_d;
            cnt_q       <= cnt_d;
            shift_start <= start_d;
            shift_len   <= len_d;
            shift_row   <= row_d;
            led_mode    <= mode_d;
            led_blank   <= blank_d;
            led_xlat    <= xlat_d;
            row_sel     <= rsel_d;
            frame_done  <= frame_d;
            underrun    <= under_d;
        end
    end

    // Next-state and next-output logic; pulses default low, levels hold.
    always_comb begin
        state_d     = state_q;
        cmd_pend_d  = cmd_pend_q;
        done_seen_d = done_seen_q;
        reload_d    = reload_q | dc_reload;
        cnt_d       = cnt_q;
        start_d     = 1'b0;
        len_d       = shift_len;
        row_d       = shift_row;
        mode_d      = led_mode;
        blank_d     = led_blank;
        xlat_d      = 1'b0;
        rsel_d      = row_sel;
        frame_d     = 1'b0;
        under_d     = underrun;

        if (done_ok) begin
            cmd_pend_d = 1'b0;
        end

        unique case (state_q)
            DC_SHIFT: begin
                blank_d = 1'b1;
                mode_d  = 1'b1;
                if (!cmd_pend_q) begin
                    start_d    = 1'b1;
                    len_d      = DC_LEN;
                    cmd_pend_d = 1'b1;
                end else if (done_ok) begin
                    state_d = DC_LATCH;
                    xlat_d  = 1'b1;
                end
            end
            DC_LATCH: begin
                state_d = PRELOAD;
                mode_d  = 1'b0;
            end
            PRELOAD: begin
                // shift_row already names the row to load: 0 after
                // reset, or the row pending when a DC reload cut in.
                if (!cmd_pend_q) begin
                    start_d    = 1'b1;
                    len_d      = GS_LEN;
                    cmd_pend_d = 1'b1;
                end else if (done_ok) begin
                    state_d = SWAP_B;
                end
            end
            SWAP_B: begin
                state_d = SWAP_X;
                blank_d = 1'b1;
                xlat_d  = 1'b1;
                rsel_d  = shift_row;
                frame_d = (shift_row == LAST_ROW);
            end
            SWAP_X: begin
                state_d     = DISPLAY;
                blank_d     = 1'b0;
                cnt_d       = '0;
                start_d     = 1'b1;
                len_d       = GS_LEN;
                row_d       = next_row;
                cmd_pend_d  = 1'b1;
                done_seen_d = 1'b0;
            end
            DISPLAY: begin
                if (gsclk_tick) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done_ok) begin
                    done_seen_d = 1'b1;
                end
                if (period_end) begin
                    blank_d = 1'b1;
                    if (reload_q) begin
                        // The next row is re-shifted after the DC load,
                        // so any done for it is dropped here.
                        state_d     = DC_SHIFT;
                        reload_d    = 1'b0;
                        cmd_pend_d  = 1'b0;
                        done_seen_d = 1'b0;
                    end else if (done_seen_q || done_ok) begin
                        state_d = SWAP_B;
                    end else begin
                        state_d = STALL;
                        under_d = 1'b1;
                    end
                end
            end
            STALL: begin
                blank_d = 1'b1;
                if (done_ok) begin
                    state_d = SWAP_B;
                end
            end
            default: begin
                state_d = DC_SHIFT;
            end
        endcase
    end

endmodule
